// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, owner IDs and the read write-mask.
// Imported by mem_arbiter and mem_arb_pick.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [3:0] WE_READ = 4'b0000;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the icache and dcache requesters.
// Define MEM_ARB_RR_EN for round-robin on collisions; otherwise the dcache always wins.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic i_valid,
  input  logic d_valid,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = i_valid | d_valid;
`ifdef MEM_ARB_RR_EN
    if (i_valid && d_valid) begin
      grant_owner = ~last_grant;
    end else begin
      grant_owner = d_valid ? OWN_D : OWN_I;
    end
`else
    grant_owner = d_valid ? OWN_D : OWN_I;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request port between icache line fills and dcache fills/stores,
// one transaction at a time. MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  output logic              i_resp_last,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [3:0]        d_req_we,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_resp_last,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [3:0]        mem_req_we,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              core_stall
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              i_rv_q, i_rv_d, i_rl_q, i_rl_d;
  logic              d_rv_q, d_rv_d, d_rl_q, d_rl_d;
  logic [DATA_W-1:0] i_rd_q, i_rd_d, d_rd_q, d_rd_d;
  logic              grant_valid, grant_owner, resp_last;
  logic [DATA_W-1:0] resp_data;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
`endif

  mem_arb_pick u_pick (
    .i_valid     (i_req_valid),
    .d_valid     (d_req_valid),
`ifdef MEM_ARB_RR_EN
    .last_grant  (last_grant_q),
`endif
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    i_rv_d      = 1'b0;
    i_rd_d      = '0;
    i_rl_d      = 1'b0;
    d_rv_d      = 1'b0;
    d_rd_d      = '0;
    d_rl_d      = 1'b0;
    // A write completes on its single ack; a read on beat BEATS-1.
    resp_last   = (we_q != WE_READ) || (beat_q == LAST_BEAT);
    resp_data   = (we_q != WE_READ) ? '0 : mem_resp_data;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          i_req_ready = (grant_owner == OWN_I);
          d_req_ready = (grant_owner == OWN_D);
          owner_d     = grant_owner;
          addr_d      = (grant_owner == OWN_D) ? d_req_addr : i_req_addr;
          we_d        = (grant_owner == OWN_D) ? d_req_we : WE_READ;
          wdata_d     = (grant_owner == OWN_D) ? d_req_wdata : '0;
          state_d     = ARB_ISSUE;
`ifdef MEM_ARB_RR_EN
          last_grant_d = grant_owner;
`endif
        end
      end
      ARB_ISSUE: begin
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (mem_resp_valid) begin
          if (owner_q == OWN_D) begin
            d_rv_d = 1'b1;
            d_rd_d = resp_data;
            d_rl_d = resp_last;
          end else begin
            i_rv_d = 1'b1;
            i_rd_d = resp_data;
            i_rl_d = resp_last;
          end
          beat_d = beat_q + BEAT_W'(1);
          if (resp_last) begin
            beat_d  = '0;
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      i_rv_q  <= 1'b0;
      i_rd_q  <= '0;
      i_rl_q  <= 1'b0;
      d_rv_q  <= 1'b0;
      d_rd_q  <= '0;
      d_rl_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= OWN_I;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      i_rv_q  <= i_rv_d;
      i_rd_q  <= i_rd_d;
      i_rl_q  <= i_rl_d;
      d_rv_q  <= d_rv_d;
      d_rd_q  <= d_rd_d;
      d_rl_q  <= d_rl_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_req_valid = (state_q == ARB_ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign i_resp_valid  = i_rv_q;
  assign i_resp_data   = i_rd_q;
  assign i_resp_last   = i_rl_q;
  assign d_resp_valid  = d_rv_q;
  assign d_resp_data   = d_rd_q;
  assign d_resp_last   = d_rl_q;
  assign core_stall    = (state_q != ARB_IDLE) | i_req_valid | d_req_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default fixed-priority build).
// Each comparison is an immediate assertion; a single summary line ends the run.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_last;
  logic [31:0] i_req_addr, i_resp_data;
  logic        d_req_valid, d_req_ready, d_resp_valid, d_resp_last;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
  logic [3:0]  d_req_we;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [3:0]  mem_req_we;
  logic        core_stall;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_last(i_resp_last),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_last(d_resp_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .core_stall(core_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full icache line fill with gap-free beats base..base+3.
  task automatic do_iread(input logic [31:0] addr, input logic [31:0] base);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    #1;
    chk("ird_i_ready", i_req_ready, 1);
    chk("ird_d_ready", d_req_ready, 0);
    chk("ird_stall_req", core_stall, 1);
    tick();
    i_req_valid = 1'b0;
    #1;
    chk("ird_mem_valid", mem_req_valid, 1);
    chk("ird_mem_addr", mem_req_addr, addr);
    chk("ird_mem_we", mem_req_we, 0);
    chk("ird_i_ready_once", i_req_ready, 0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("ird_mem_valid_drop", mem_req_valid, 0);
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = base + 32'(k);
      tick();
      chk("ird_resp_valid", i_resp_valid, 1);
      chk("ird_resp_data", i_resp_data, base + 32'(k));
      chk("ird_resp_last", i_resp_last, (k == 3) ? 1 : 0);
      chk("ird_d_quiet", d_resp_valid, 0);
      $display("iread addr=%h beat=%0d data=%h last=%0b", addr, k, i_resp_data, i_resp_last);
    end
    mem_resp_valid = 1'b0;
    #1;
    chk("ird_stall_done", core_stall, 0);
    tick();
    chk("ird_resp_clear", i_resp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 0; i_req_addr = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_i_resp", i_resp_valid, 0);
    chk("rst_d_resp", d_resp_valid, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_i_ready", i_req_ready, 0);
    $display("reset done");

    // Icache-only read
    do_iread(32'h100, 32'hA0);

    // Spurious response while idle
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h55;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("spur_i_resp", i_resp_valid, 0);
    chk("spur_d_resp", d_resp_valid, 0);
    chk("spur_mem_valid", mem_req_valid, 0);
    chk("spur_stall", core_stall, 0);
    $display("spurious response dropped");

    // Simultaneous requests: dcache write wins, with backpressure
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    d_req_valid = 1'b1; d_req_addr = 32'h300; d_req_we = 4'b1111; d_req_wdata = 32'hDEADBEEF;
    #1;
    chk("sim_d_ready", d_req_ready, 1);
    chk("sim_i_ready", i_req_ready, 0);
    tick();
    d_req_valid = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h77;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_mem_valid", mem_req_valid, 1);
      chk("bp_mem_addr", mem_req_addr, 32'h300);
      chk("bp_mem_we", mem_req_we, 4'b1111);
      chk("bp_mem_wdata", mem_req_wdata, 32'hDEADBEEF);
      chk("bp_d_resp", d_resp_valid, 0);
      chk("bp_i_resp", i_resp_valid, 0);
      chk("bp_i_ready", i_req_ready, 0);
      chk("bp_stall", core_stall, 1);
      $display("backpressure cycle=%0d mem_req_valid=%0b", c, mem_req_valid);
      tick();
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("wack_valid", d_resp_valid, 1);
    chk("wack_last", d_resp_last, 1);
    chk("wack_data", d_resp_data, 0);
    chk("wack_i_quiet", i_resp_valid, 0);
    chk("wack_i_grant", i_req_ready, 1);
    $display("write ack valid=%0b last=%0b data=%h", d_resp_valid, d_resp_last, d_resp_data);
    tick();
    i_req_valid = 1'b0;
    #1;
    chk("next_i_mem_valid", mem_req_valid, 1);
    chk("next_i_mem_addr", mem_req_addr, 32'h200);
    chk("next_i_mem_we", mem_req_we, 0);
    chk("next_d_resp_clear", d_resp_valid, 0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hB0 + 32'(k);
      tick();
      chk("ib_resp_data", i_resp_data, 32'hB0 + 32'(k));
      chk("ib_resp_last", i_resp_last, (k == 3) ? 1 : 0);
      $display("iread addr=200 beat=%0d data=%h", k, i_resp_data);
    end
    mem_resp_valid = 1'b0;
    tick();

    // Dcache read burst aborted by reset after beat 2
    d_req_valid = 1'b1; d_req_addr = 32'h400; d_req_we = 4'b0000; d_req_wdata = 0;
    #1;
    chk("drd_ready", d_req_ready, 1);
    tick();
    d_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hC0 + 32'(k);
      tick();
      chk("drd_resp_valid", d_resp_valid, 1);
      chk("drd_resp_data", d_resp_data, 32'hC0 + 32'(k));
      chk("drd_resp_last", d_resp_last, 0);
      $display("dread beat=%0d data=%h", k, d_resp_data);
    end
    rst = 1'b1;
    mem_resp_data = 32'hC2;
    tick();
    rst = 1'b0;
    mem_resp_data = 32'hC3;
    #1;
    chk("abort_d_resp", d_resp_valid, 0);
    chk("abort_d_data", d_resp_data, 0);
    chk("abort_mem_valid", mem_req_valid, 0);
    chk("abort_stall", core_stall, 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("late_d_resp", d_resp_valid, 0);
    chk("late_i_resp", i_resp_valid, 0);
    $display("reset abort, late beats dropped");

    do_iread(32'h500, 32'hE0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
